// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream stages.
//
// Contents:
//   DEF_DATA_WIDTH / DEF_RATIO : default beat width and packing ratio.
//   keep_t                     : lane-valid mask for the default ratio.
//   lane_lsb()                 : bit offset of a lane inside a packed word.
package stream_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RATIO      = 4;

    typedef logic [DEF_RATIO-1:0] keep_t;

    // Lane k of a packed word occupies bits [k*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/stream_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   load                 : capture load_data/keep/last; out_valid=1 next cycle
//   load_data/keep/last  : word to capture
//   slot_free            : slot can accept a load this cycle (~out_valid | out_ready)
//   out_data/keep/last   : word presented downstream
//   out_valid, out_ready : downstream handshake
module stream_out_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    output logic                  slot_free,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    assign slot_free = ~out_valid | out_ready;

    // NOTE: the data/keep/last storage is reset as well, because its reset
    // value of zero is visible on the output ports.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_ready) begin
            // Word consumed and nothing replaces it; payload may go stale.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO consecutive DATA_WIDTH beats into one OUT_WIDTH word.
// in_last closes a partial word early; out_keep marks the lanes that hold
// real beats and out_last reports that the word was closed by in_last.
// One word can be under assembly while another waits in the output slot,
// so a full input rate is sustained and in_ready comes straight from a flop.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_data, in_valid, in_last   : narrow input beat
//   in_ready                     : upstream may transfer (~acc_pend)
//   out_data, out_keep, out_last : packed wide word, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid, out_ready         : downstream handshake
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int   RATIO      = DEF_RATIO,
    localparam int  OUT_WIDTH  = DATA_WIDTH * RATIO,
    localparam int  CNT_WIDTH  = $clog2(RATIO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [RATIO-1:0]      out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [CNT_WIDTH-1:0]  cnt;
    logic [OUT_WIDTH-1:0]  acc_data;
    logic [RATIO-1:0]      acc_keep;
    logic                  acc_last;
    logic                  acc_pend;

    logic                  in_exec;
    logic                  word_done;
    logic                  slot_free;
    logic                  slot_load;
    logic [OUT_WIDTH-1:0]  merged_data;
    logic [RATIO-1:0]      merged_keep;
    logic [OUT_WIDTH-1:0]  load_data;
    logic [RATIO-1:0]      load_keep;
    logic                  load_last;

    // acc_pend is a flop, so there is no path from out_ready to in_ready.
    assign in_ready  = ~acc_pend;
    assign in_exec   = in_valid & in_ready;
    assign word_done = (cnt == CNT_WIDTH'(RATIO - 1)) | in_last;

    // Accumulator with the current beat written into lane cnt.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        merged_data[lane_lsb(int'(cnt), DATA_WIDTH) +: DATA_WIDTH] = in_data;
        merged_keep[cnt] = 1'b1;
    end

    // A pending word always has priority: no beat is accepted while it waits.
    assign slot_load = slot_free & (acc_pend | (in_exec & word_done));
    assign load_data = acc_pend ? acc_data : merged_data;
    assign load_keep = acc_pend ? acc_keep : merged_keep;
    assign load_last = acc_pend ? acc_last : in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
            acc_pend <= 1'b0;
        end else if (acc_pend) begin
            if (slot_free) begin
                acc_pend <= 1'b0;
                acc_data <= '0;
                acc_keep <= '0;
                acc_last <= 1'b0;
            end
        end else if (in_exec) begin
            if (word_done) begin
                cnt <= '0;
                if (slot_free) begin
                    // Word leaves through the slot; start clean so unfilled
                    // lanes of the next partial word read as zero.
                    acc_data <= '0;
                    acc_keep <= '0;
                    acc_last <= 1'b0;
                end else begin
                    acc_data <= merged_data;
                    acc_keep <= merged_keep;
                    acc_last <= in_last;
                    acc_pend <= 1'b1;
                end
            end else begin
                acc_data <= merged_data;
                acc_keep <= merged_keep;
                cnt      <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    stream_out_slot #(
        .DATA_WIDTH (OUT_WIDTH),
        .KEEP_WIDTH (RATIO)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (slot_load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .slot_free (slot_free),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed and randomized checks of stream_upsizer (DATA_WIDTH=8, RATIO=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stream_upsizer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t exp_q[$];

    stream_upsizer #(
        .DATA_WIDTH (8),
        .RATIO      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then back to the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".keep"},  64'(out_keep),  64'(k));
        check({tag, ".last"},  64'(out_last),  64'(l));
    endtask

    initial begin
        logic [31:0] m_data;
        logic [3:0]  m_keep;
        int          m_cnt;
        int          beats;
        int          cycles;
        logic        hold;
        logic        iexec;
        logic        oexec;
        word_t       w;
        word_t       got;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // ---- reset values ----
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'(1'b0));
        check("rst.out_data",  64'(out_data),  64'(0));
        check("rst.out_keep",  64'(out_keep),  64'(0));
        check("rst.out_last",  64'(out_last),  64'(0));
        check("rst.in_ready",  64'(in_ready),  64'(1'b1));
        rst_n = 1'b1;
        step();

        // ---- four back-to-back beats, one cycle latency ----
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h11 * (i + 1));
            check($sformatf("t1.in_ready%0d", i), 64'(in_ready), 64'(1'b1));
            if (i == 3) check("t1.no_early_valid", 64'(out_valid), 64'(1'b0));
            step();
        end
        in_valid = 1'b0;
        check_word("t1.word", 32'h44332211, 4'b1111, 1'b0);

        // ---- 12 beats back-to-back, three words ----
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'(i + 1);
            check($sformatf("t2.in_ready%0d", i), 64'(in_ready), 64'(1'b1));
            step();
            if (i % 4 == 3)
                check_word($sformatf("t2.word%0d", i / 4),
                           {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)}, 4'b1111, 1'b0);
            else
                check($sformatf("t2.gap%0d", i), 64'(out_valid), 64'(1'b0));
        end
        in_valid = 1'b0;

        // ---- early termination ----
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b1);
        check_word("t3.partial", 32'h0000A2A1, 4'b0011, 1'b1);
        beat(8'hB5, 1'b1);
        check_word("t3.single", 32'h000000B5, 4'b0001, 1'b1);
        step();
        check("t3.drained", 64'(out_valid), 64'(1'b0));

        // ---- backpressure: slot held, second word pending ----
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) beat(8'(i), 1'b0);
        check("t4.in_ready_low", 64'(in_ready), 64'(1'b0));
        check_word("t4.held", 32'h04030201, 4'b1111, 1'b0);
        step();
        check("t4.still_stalled", 64'(in_ready), 64'(1'b0));
        check("t4.held_stable", 64'(out_data), 64'(32'h04030201));
        out_ready = 1'b1;
        step();
        check_word("t4.second", 32'h08070605, 4'b1111, 1'b0);
        check("t4.in_ready_back", 64'(in_ready), 64'(1'b1));
        step();
        check("t4.empty", 64'(out_valid), 64'(1'b0));

        // ---- reset mid-word, then a clean word ----
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5.mid.out_valid", 64'(out_valid), 64'(1'b0));
        check("t5.mid.out_keep",  64'(out_keep),  64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) beat(8'(8'hC0 + i), 1'b0);
        check_word("t5.clean1", 32'hC4C3C2C1, 4'b1111, 1'b0);

        // ---- reset while acc_pend=1 ----
        out_ready = 1'b0;
        step();
        for (int i = 1; i <= 8; i++) beat(8'(8'h20 + i), 1'b0);
        check("t5.pend.in_ready", 64'(in_ready), 64'(1'b0));
        rst_n = 1'b0;
        #1;
        check("t5.pend.out_valid", 64'(out_valid), 64'(1'b0));
        check("t5.pend.out_keep",  64'(out_keep),  64'(0));
        check("t5.pend.in_ready",  64'(in_ready),  64'(1'b1));
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5.no_residue", 64'(out_valid), 64'(1'b0));
        beat(8'hD1, 1'b0);
        beat(8'hD2, 1'b1);
        check_word("t5.clean2", 32'h0000D2D1, 4'b0011, 1'b1);
        step();

        // ---- randomized traffic against a packing model ----
        m_data = '0;
        m_keep = '0;
        m_cnt  = 0;
        beats  = 0;
        cycles = 0;
        hold   = 1'b0;
        while (beats < 10000 && cycles < 60000) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 7) == 0);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            iexec = in_valid & in_ready;
            oexec = out_valid & out_ready;
            if (oexec) begin
                got.d = out_data;
                got.k = out_keep;
                got.l = out_last;
                if (exp_q.size() == 0) begin
                    check("rnd.unexpected_word", 64'(1), 64'(0));
                end else begin
                    w = exp_q.pop_front();
                    check("rnd.word", {got.d, 27'(0), got.k, got.l},
                                      {w.d,   27'(0), w.k,   w.l});
                end
            end
            if (iexec) begin
                m_data[m_cnt*8 +: 8] = in_data;
                m_keep[m_cnt] = 1'b1;
                if (m_cnt == 3 || in_last) begin
                    w.d = m_data;
                    w.k = m_keep;
                    w.l = in_last;
                    exp_q.push_back(w);
                    m_data = '0;
                    m_keep = '0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
                beats++;
            end
            // A valid beat that was not taken must be held unchanged.
            hold = in_valid & ~iexec;
            step();
            cycles++;
        end
        check("rnd.cycle_budget", 64'(cycles < 60000), 64'(1));

        // Drain whatever completed words remain.
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (exp_q.size() > 0 && cycles < 20) begin
            #1;
            if (out_valid) begin
                w = exp_q.pop_front();
                check("rnd.drain_word", {out_data, 27'(0), out_keep, out_last},
                                        {w.d,      27'(0), w.k,      w.l});
            end
            step();
            cycles++;
        end
        check("rnd.all_words_seen", 64'(exp_q.size()), 64'(0));
        check("rnd.no_extra_word", 64'(out_valid), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
